mac_pipe: RTL and testbench

Parametrised multiply-accumulate engine and next-generation MAC for the datapath.
- Configurable operand and accumulator widths.
- Signed or unsigned arithmetic.
- Optional saturation, with a sticky overflow flag.
- A valid pipeline keeps every enabled operand pair aligned with its accumulate.
- Feeds the FIFO/result path; downstream uses Cout_vld to capture partial sums.

---
 rtl/mac_pkg.sv | 49 ++++
 rtl/mac_sat_add.sv | 36 +++
 rtl/mac_pipe.sv | 94 +++++++++
 tb/tb_mac_pipe.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, clamp helpers and the extended add with overflow detect for the MAC pipeline.
// Functions work at a fixed maximum width; callers pass the accumulator MSB index.
package mac_pkg;

  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic [MAX_W:0] sum;
    logic           ovf;
    logic           neg;
  } add_res_t;

  // a and b are zero-padded accumulator-width values; msb selects the real sign/carry position.
  function automatic add_res_t ext_add(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic [5:0]       msb,
                                       input logic             is_signed);
    add_res_t   r;
    logic [6:0] cy;
    r     = '0;
    cy    = {1'b0, msb} + 7'd1;
    r.sum = {1'b0, a} + {1'b0, b};
    if (is_signed) begin
      r.ovf = (a[msb] == b[msb]) && (r.sum[msb] != a[msb]);
      r.neg = a[msb];
    end else begin
      r.ovf = r.sum[cy];
      r.neg = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] sat_umax(input logic [5:0] msb);
    return ((MAX_W'(1) << msb) << 1) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_smax(input logic [5:0] msb);
    return (MAX_W'(1) << msb) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_smin(input logic [5:0] msb);
    return MAX_W'(1) << msb;
  endfunction

  function automatic bit acc_w_ok(input int data_w, input int acc_w);
    return (data_w >= 1) && (acc_w >= 2 * data_w) && (acc_w <= int'(MAX_W));
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational accumulate step: acc + extended product, with overflow detect and optional clamp.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_prod_ext,
  output logic [ACC_W-1:0] o_acc_nxt,
  output logic             o_ovf_detect
);

  localparam logic [5:0]       L_MSB  = 6'(ACC_W - 1);
  localparam logic [ACC_W-1:0] L_UMAX = ACC_W'(sat_umax(L_MSB));
  localparam logic [ACC_W-1:0] L_SMAX = ACC_W'(sat_smax(L_MSB));
  localparam logic [ACC_W-1:0] L_SMIN = ACC_W'(sat_smin(L_MSB));

  add_res_t w_res;
  logic     w_unused_hi;

  assign w_unused_hi = ^w_res.sum[MAX_W:ACC_W];

  always_comb begin
    w_res        = ext_add(MAX_W'(i_acc), MAX_W'(i_prod_ext), L_MSB, SIGNED != 0);
    o_ovf_detect = w_res.ovf;
    o_acc_nxt    = ACC_W'(w_res.sum);
    // Signed overflow only happens with equal operand signs, so the acc sign picks the rail.
    if ((SATURATE != 0) && w_res.ovf) begin
      if (SIGNED != 0) o_acc_nxt = w_res.neg ? L_SMIN : L_SMAX;
      else             o_acc_nxt = L_UMAX;
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate: stage 1 registers the product, stage 2 accumulates it.
// Valid/handshake: En qualifies Ain/Bin for one cycle; Cout_vld pulses the cycle after each accumulate.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic              Clr,
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  output logic [ACC_W-1:0]  Cout,
  output logic              Cout_vld,
  output logic              ovf,
  output logic [CNT_W-1:0]  cnt
);

  if (!acc_w_ok(DATA_W, ACC_W)) begin : g_bad_width
    $error("mac_pipe: ACC_W must be >= 2*DATA_W and <= %0d", MAX_W);
  end

  logic [2*DATA_W-1:0] r_prod;
  logic                r_v1;
  logic [ACC_W-1:0]    r_acc;
  logic                r_vld;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;

  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic                w_ovf_det;

  // Operands are extended to full product width first so the low bits are exact either way.
  always_comb begin
    if (SIGNED != 0) begin
      w_prod     = $signed({{DATA_W{Ain[DATA_W-1]}}, Ain}) * $signed({{DATA_W{Bin[DATA_W-1]}}, Bin});
      w_prod_ext = ACC_W'($signed(r_prod));
    end else begin
      w_prod     = {{DATA_W{1'b0}}, Ain} * {{DATA_W{1'b0}}, Bin};
      w_prod_ext = ACC_W'(r_prod);
    end
  end

  mac_sat_add #(
    .ACC_W    (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_acc        (r_acc),
    .i_prod_ext   (w_prod_ext),
    .o_acc_nxt    (w_acc_nxt),
    .o_ovf_detect (w_ovf_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_v1   <= 1'b0;
      r_acc  <= '0;
      r_vld  <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else if (Clr) begin
      // Clear also kills the product already in stage 1 by dropping its valid.
      r_v1  <= 1'b0;
      r_acc <= '0;
      r_vld <= 1'b0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_v1 <= En;
      if (En) r_prod <= w_prod;
      r_vld <= r_v1;
      if (r_v1) begin
        r_acc <= w_acc_nxt;
        r_ovf <= r_ovf | w_ovf_det;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign Cout     = r_acc;
  assign Cout_vld = r_vld;
  assign ovf      = r_ovf;
  assign cnt      = r_cnt;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default, wrapping and signed instances share one stimulus stream.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr;
  logic [7:0]  ain, bin;

  logic [23:0] d_cout, w_cout, s_cout;
  logic        d_vld, w_vld, s_vld;
  logic        d_ovf, w_ovf, s_ovf;
  logic [15:0] d_cnt, w_cnt, s_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_pipe u_def (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Ain(ain), .Bin(bin),
    .Cout(d_cout), .Cout_vld(d_vld), .ovf(d_ovf), .cnt(d_cnt)
  );

  mac_pipe #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Ain(ain), .Bin(bin),
    .Cout(w_cout), .Cout_vld(w_vld), .ovf(w_ovf), .cnt(w_cnt)
  );

  mac_pipe #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Ain(ain), .Bin(bin),
    .Cout(s_cout), .Cout_vld(s_vld), .ovf(s_ovf), .cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ain = '0; bin = '0;

    // Reset state
    #2;
    chk("rst_cout", d_cout, 0);
    chk("rst_vld",  d_vld,  0);
    chk("rst_ovf",  d_ovf,  0);
    chk("rst_cnt",  d_cnt,  0);
    @(negedge clk) rst_n = 1'b1;

    // Basic latency, then hold with X operands
    en = 1'b1; ain = 8'd3; bin = 8'd4;
    tick();
    chk("lat_vld_early", d_vld, 0);
    en = 1'b0; ain = 'x; bin = 'x;
    tick();
    chk("lat_cout", d_cout, 12);
    chk("lat_vld",  d_vld,  1);
    chk("lat_cnt",  d_cnt,  1);
    chk("lat_sgn",  s_cout, 12);
    tick();
    tick();
    chk("hold_cout", d_cout, 12);
    chk("hold_vld",  d_vld,  0);

    // Streaming four pairs back to back
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_cout", d_cout, 0);
    pulses = 0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ain = 8'(2 * i + 1); bin = 8'(2 * i + 2);
      tick();
      if (d_vld) pulses++;
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (d_vld) pulses++;
    end
    chk("strm_cout",   d_cout, 100);
    chk("strm_cnt",    d_cnt,  4);
    chk("strm_pulses", pulses, 4);

    // Unsigned saturation vs wrap
    clr = 1'b1; tick(); clr = 1'b0;
    en = 1'b1; ain = 8'd255; bin = 8'd255;
    repeat (258) tick();
    en = 1'b0;
    tick();
    chk("usat258_cout", d_cout, 16776450);
    chk("usat258_ovf",  d_ovf,  0);
    chk("wrap258_cout", w_cout, 16776450);
    chk("wrap258_ovf",  w_ovf,  0);
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("usat259_cout", d_cout, 24'hFFFFFF);
    chk("usat259_ovf",  d_ovf,  1);
    chk("usat259_cnt",  d_cnt,  259);
    chk("wrap259_cout", w_cout, 259 * 65025 - 16777216);
    chk("wrap259_ovf",  w_ovf,  1);
    tick();
    chk("usat_sticky",  d_ovf,  1);

    // Signed accumulate and negative clamp
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ovf", d_ovf, 0);
    en = 1'b1; ain = 8'h80; bin = 8'h7F;
    tick();
    ain = 8'h05; bin = 8'hFD;
    tick();
    en = 1'b0;
    tick();
    chk("sgn_cout", s_cout, 24'hFFC071);
    chk("sgn_ovf",  s_ovf,  0);
    en = 1'b1; ain = 8'h80; bin = 8'h7F;
    repeat (600) tick();
    en = 1'b0;
    tick();
    chk("sgn_clamp", s_cout, 24'h800000);
    chk("sgn_ovf2",  s_ovf,  1);
    chk("sgn_cnt",   s_cnt,  602);

    // Clear colliding with an in-flight product and a new pair
    en = 1'b1; ain = 8'd2; bin = 8'd2;
    tick();
    ain = 8'd3; bin = 8'd3; clr = 1'b1;
    tick();
    en = 1'b0; clr = 1'b0;
    chk("clrc_cout_e2", d_cout, 0);
    chk("clrc_vld_e2",  d_vld,  0);
    tick();
    chk("clrc_cout", d_cout, 0);
    chk("clrc_cnt",  d_cnt,  0);
    chk("clrc_ovf",  s_ovf,  0);
    chk("clrc_vld",  d_vld,  0);
    en = 1'b1; ain = 8'd1; bin = 8'd1;
    tick();
    en = 1'b0;
    tick();
    chk("clrc_next", d_cout, 1);

    // Async reset in the middle of a stream
    en = 1'b1; ain = 8'd9; bin = 8'd9;
    repeat (3) tick();
    chk("ar_pre", d_cout, 1 + 81 + 81);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_cout", d_cout, 0);
    chk("ar_vld",  d_vld,  0);
    chk("ar_cnt",  d_cnt,  0);
    chk("ar_ovf",  d_ovf,  0);
    ain = 8'd6; bin = 8'd7;
    @(negedge clk) rst_n = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("ar_first_cout", d_cout, 42);
    chk("ar_first_cnt",  d_cnt,  1);
    chk("ar_first_sgn",  s_cout, 42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
